conv_maxpool_rx: RTL and testbench
==================================

# conv_maxpool_rx

Receiving end of the convolution engine's output stream. Accepts 9-bit unsigned convolution results in raster order, one per `in_valid` strobe. Applies 2x2 stride-2 max pooling over an FW x FH feature map and emits pooled values with a valid/last strobe. Drives the `ready` that gates the convolution controller, and checks that the controller's `finish` lines up with the final pixel.

## Interface
- `FW`, 4: feature-map width in pixels; even, >= 2
- `FH`, 4: feature-map height in pixels; even, >= 2
- `DW`, 9: data width; matches the convolution `out` width

- `clk`  in  1  sole clock; all logic on the rising edge
- `rst`  in  1  synchronous reset, active-high
- `start`  in  1  one-cycle pulse that arms reception of one frame
- `ready`  out  1  high while the block accepts pixels; wired to the convolution controller's `ready`
- `in_valid`  in  1  `in_data` is valid this cycle
- `in_data`  in  DW  convolution result, unsigned
- `in_last`  in  1  controller `finish`; must coincide with the final pixel
- `out_valid`  out  1  pooled value valid; single-cycle pulse
- `out_data`  out  DW  pooled maximum
- `out_last`  out  1  with `out_valid` on the last pooled value of the frame
- `done`  out  1  sticky; frame complete; cleared by `start` or `rst`
- `err`  out  1  sticky protocol error; cleared by `start` or `rst`

## Operation
- States: IDLE, RECV.
  - IDLE -> RECV on `start`. Clears col/row counters, `done` and `err`.
  - RECV -> IDLE after the pixel at (row FH-1, col FW-1) is accepted, or when `in_last` is accepted early.
  - `start` in RECV is ignored.
- `ready` = (state == RECV). An input is accepted only when `in_valid && ready`. `in_valid` in IDLE is ignored.
- Counters `col` (0..FW-1) and `row` (0..FH-1) advance per accepted pixel. `col` wraps to 0 and increments `row`.
- Pair register `pr`:
  - On an even column, `pr <= in_data`.
  - On an odd column, compute `hm = max(pr, in_data)`.
- Line buffer `lb[FW/2]`:
  - Even row, odd col: `lb[col/2] <= hm`.
  - Odd row, odd col: the result `max(hm, lb[col/2])` is registered to `out_data` and `out_valid` is pulsed.
- All comparisons are unsigned, full DW bits. No saturation is needed because the max never exceeds the inputs.
- `out_last` accompanies the output produced by pixel (FH-1, FW-1). `done` sets in the same cycle as `out_last`.
- `in_last` checking:
  - On an accepted pixel that is not the final one: `err` <= 1 and the state returns to IDLE. No further outputs are produced for that frame, and `done` stays 0.
  - If the final pixel is accepted without `in_last`: `err` <= 1, but the output and `done` still occur.
- Output count per frame is (FW/2)*(FH/2).

## Timing
- Reset values: `ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `done`=0, `err`=0. State is IDLE and counters are 0. `lb` and `pr` contents are don't-care.
- `ready` rises the cycle after `start` is sampled, and falls the cycle after the final or early-last pixel is accepted.
- Latency: `out_valid` is high exactly 1 cycle after the odd-row, odd-col pixel is accepted.
- `in_valid` may have gaps of any length. Counters and outputs hold while `in_valid` = 0.
- Throughput: one pixel per cycle, with no back-pressure on the output side.
- `rst` mid-frame: everything returns to reset values on the next edge. No partial output follows.
- `start` and `rst` in the same cycle: `rst` wins.
- A new `start` the cycle after a frame completes is accepted. Back-to-back frames require no idle cycles beyond that.

## Test plan
- FW=FH=4, `start`, then stream pixels 0..15 continuously with `in_last` on 15. Expect `out_valid` pulses carrying 5, 7, 13, 15; `out_last` with 15; `done`=1; `err`=0; `ready` low after the 16th pixel.
- Same frame with descending data 15..0 and random 1-3 cycle `in_valid` gaps. Expect outputs 15, 13, 7, 5, each 1 cycle after pixels 5, 7, 13, 15 are accepted.
- Width/unsigned check: a 4x4 frame with all values 0 except pixel 6 = 511 (0x1FF) and pixel 9 = 256. Expect outputs 0, 511, 256, 0.
- Early finish: `in_last` on pixel 9. Expect `err`=1, `ready`=0 next cycle, only outputs 5 and 7, `done`=0. A following `start` clears `err`.
- Ignore rules: `in_valid` with data 99 before `start` produces no output and no counter movement. `start` pulsed mid-frame does not change the output sequence.
- Reset mid-frame: assert `rst` after pixel 6. All outputs are 0 next cycle. A new `start` plus the full 0..15 frame yields 5, 7, 13, 15 normally.

Source files
------------

// File: rtl/conv_maxpool_rx_if.sv
// Stream interface between the convolution output and the 2x2 max-pool receiver.
interface conv_maxpool_rx_if #(
   parameter int unsigned DW = 9
);
   logic          start;
   logic          ready;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          done;
   logic          err;

   modport master (
      output start, in_valid, in_data, in_last,
      input  ready, out_valid, out_data, out_last, done, err
   );

   modport slave (
      input  start, in_valid, in_data, in_last,
      output ready, out_valid, out_data, out_last, done, err
   );
endinterface

// File: rtl/conv_maxpool_rx.sv
// Receives raster-order convolution results, applies 2x2 stride-2 max pooling,
// and checks that the controller's finish strobe lines up with the final pixel.
module conv_maxpool_rx #(
   parameter int unsigned FW = 4,
   parameter int unsigned FH = 4,
   parameter int unsigned DW = 9
) (
   input logic              clk,
   input logic              rst,
   conv_maxpool_rx_if.slave rx
);
   localparam int unsigned CW = (FW > 1) ? $clog2(FW) : 1;
   localparam int unsigned RW = (FH > 1) ? $clog2(FH) : 1;
   localparam int unsigned LN = FW / 2;
   localparam int unsigned LW = (LN > 1) ? $clog2(LN) : 1;

   typedef enum logic {IDLE, RECV} state_e;

   state_e        state_q;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [DW-1:0] pr_q;
   logic [DW-1:0] lb_q [LN];
   logic          out_valid_q;
   logic [DW-1:0] out_data_q;
   logic          out_last_q;
   logic          done_q;
   logic          err_q;

   logic          accept;
   logic          col_last;
   logic          is_final;
   logic [LW-1:0] lb_idx;
   logic [DW-1:0] hm_d;
   logic [DW-1:0] pool_d;

   // Horizontal max of the current pair, then vertical max against the line buffer.
   always_comb begin
      accept   = rx.in_valid && (state_q == RECV);
      col_last = (col_q == CW'(FW - 1));
      is_final = col_last && (row_q == RW'(FH - 1));
      lb_idx   = LW'(col_q >> 1);
      hm_d     = (pr_q > rx.in_data) ? pr_q : rx.in_data;
      pool_d   = (hm_d > lb_q[lb_idx]) ? hm_d : lb_q[lb_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx.start) begin
                  state_q <= RECV;
                  col_q   <= '0;
                  row_q   <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
               end
            end
            RECV: begin
               if (accept) begin
                  if (!col_q[0]) begin
                     pr_q <= rx.in_data;
                  end else if (!row_q[0]) begin
                     lb_q[lb_idx] <= hm_d;
                  end else begin
                     out_data_q  <= pool_d;
                     out_valid_q <= 1'b1;
                     out_last_q  <= is_final;
                     if (is_final) done_q <= 1'b1;
                  end

                  if (col_last) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end

                  // A missing finish on the final pixel still completes the frame;
                  // an early finish aborts it.
                  if (is_final) begin
                     state_q <= IDLE;
                     if (!rx.in_last) err_q <= 1'b1;
                  end else if (rx.in_last) begin
                     state_q <= IDLE;
                     err_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx.ready     = (state_q == RECV);
   assign rx.out_valid = out_valid_q;
   assign rx.out_data  = out_data_q;
   assign rx.out_last  = out_last_q;
   assign rx.done      = done_q;
   assign rx.err       = err_q;
endmodule

// File: tb/tb_conv_maxpool_rx.sv
// Directed bench for conv_maxpool_rx on a 4x4 map with hand-computed pooled outputs.
module tb_conv_maxpool_rx;
   typedef logic [8:0] frame_t [16];
   typedef logic [8:0] pool_t [4];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   conv_maxpool_rx_if #(.DW(9)) bus ();

   conv_maxpool_rx #(.FW(4), .FH(4), .DW(9)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (bus)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one pixel for one cycle, then check the output strobe it produced.
   task automatic pix(input string tag, input logic [8:0] d, input logic last, input logic strt,
                      input logic ev, input logic [8:0] ed, input logic el);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      bus.start    = strt;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.start    = 1'b0;
      check_eq({tag, "_vld"}, 32'(bus.out_valid), 32'(ev));
      if (ev) begin
         check_eq({tag, "_data"}, 32'(bus.out_data), 32'(ed));
         check_eq({tag, "_last"}, 32'(bus.out_last), 32'(el));
      end
   endtask

   task automatic do_start(input string tag);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_eq({tag, "_rdy_up"}, 32'(bus.ready), 32'd1);
      check_eq({tag, "_done_clr"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_err_clr"}, 32'(bus.err), 32'd0);
   endtask

   // last_at = 16 means no in_last is ever sent.
   task automatic run_frame(input string tag, input frame_t d, input pool_t e,
                            input int last_at, input int max_gap, input int start_at);
      int   o;
      int   n;
      logic ev;
      o = 0;
      n = (last_at < 16) ? last_at + 1 : 16;
      do_start(tag);
      for (int k = 0; k < n; k++) begin
         ev = (((k / 4) % 2) == 1) && ((k % 2) == 1);
         pix(tag, d[k], k == last_at, k == start_at, ev, (ev && o < 4) ? e[o] : 9'd0, k == 15);
         if (ev) o++;
         if (max_gap > 0 && k < n - 1) begin
            repeat ($urandom_range(max_gap, 1)) @(negedge clk);
            check_eq({tag, "_gap_vld"}, 32'(bus.out_valid), 32'd0);
         end
      end
      check_eq({tag, "_rdy_down"}, 32'(bus.ready), 32'd0);
      check_eq({tag, "_done"}, 32'(bus.done), 32'(n == 16));
      check_eq({tag, "_err"}, 32'(bus.err), 32'(last_at != 15));
   endtask

   initial begin
      frame_t asc, dsc, wid;
      pool_t  e_asc, e_dsc, e_wid, e_early;
      for (int k = 0; k < 16; k++) begin
         asc[k] = 9'(k);
         dsc[k] = 9'(15 - k);
         wid[k] = 9'd0;
      end
      wid[6]  = 9'd511;
      wid[9]  = 9'd256;
      e_asc   = '{9'd5, 9'd7, 9'd13, 9'd15};
      e_dsc   = '{9'd15, 9'd13, 9'd7, 9'd5};
      e_wid   = '{9'd0, 9'd511, 9'd256, 9'd0};
      e_early = '{9'd5, 9'd7, 9'd0, 9'd0};

      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_ready", 32'(bus.ready), 32'd0);
      check_eq("rst_vld", 32'(bus.out_valid), 32'd0);
      check_eq("rst_data", 32'(bus.out_data), 32'd0);
      check_eq("rst_last", 32'(bus.out_last), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_err", 32'(bus.err), 32'd0);

      // Pixel offered while idle must be ignored entirely.
      pix("idle99", 9'd99, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0);
      check_eq("idle_err", 32'(bus.err), 32'd0);

      run_frame("asc", asc, e_asc, 15, 0, 3);
      run_frame("dsc", dsc, e_dsc, 15, 3, -1);
      run_frame("wid", wid, e_wid, 15, 0, -1);
      run_frame("early", asc, e_early, 9, 0, -1);
      pix("post_early", 9'd42, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0);
      run_frame("nolast", asc, e_asc, 16, 0, -1);

      // Reset mid-frame after pixel 6.
      do_start("mid");
      for (int k = 0; k < 7; k++)
         pix("mid", asc[k], 1'b0, 1'b0, k == 5, 9'd5, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("mid_rst_ready", 32'(bus.ready), 32'd0);
      check_eq("mid_rst_vld", 32'(bus.out_valid), 32'd0);
      check_eq("mid_rst_data", 32'(bus.out_data), 32'd0);
      check_eq("mid_rst_last", 32'(bus.out_last), 32'd0);
      check_eq("mid_rst_done", 32'(bus.done), 32'd0);
      check_eq("mid_rst_err", 32'(bus.err), 32'd0);
      run_frame("after_rst", asc, e_asc, 15, 0, -1);

      repeat (3) @(negedge clk);
      check_eq("tail_vld", 32'(bus.out_valid), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
